// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared grid constants, tile states and game-status encoding
package bomb_pkg;
    localparam int GRID_W = 16;
    localparam int GRID_N = 256;

    typedef enum logic [1:0] {
        NOT_OVER  = 2'd0,
        GAME_OVER = 2'd1,
        P1_WIN    = 2'd2,
        P2_WIN    = 2'd3
    } game_status_e;

    localparam logic [2:0] EMPTY   = 3'd0;
    localparam logic [2:0] WALL    = 3'd1;
    localparam logic [2:0] BRICK   = 3'd2;
    localparam logic [2:0] BOMB    = 3'd3;
    localparam logic [2:0] EXP_H   = 3'd4;
    localparam logic [2:0] EXP_V   = 3'd5;
    localparam logic [2:0] EXP_END = 3'd6;
    localparam logic [2:0] EXP_CEN = 3'd7;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction
endpackage

// File: rtl/player_health.sv
// rtl/player_health.sv - per-player blast detection, immunity window, lives and hit pulse
module player_health
    import bomb_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int INVULN_CYCLES = 45
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              reinit,
    input  logic [GRID_N-1:0] explode,
    input  logic [7:0]        cor,
    output logic [1:0]        lives,
    output logic [1:0]        lives_next,
    output logic              hit,
    output logic              invuln
);
    localparam int CW = $clog2(INVULN_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          accept;

    assign accept = enable && explode[cor] && (cnt == '0);

    // lives_next feeds the round-end decision on the same edge as the decrement
    always_comb begin
        lives_next = lives;
        cnt_next   = cnt;
        if (accept) begin
            cnt_next = CW'(INVULN_CYCLES);
            if (lives != 2'd0) lives_next = lives - 2'd1;
        end else if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || reinit) begin
            lives  <= 2'(LIVES);
            cnt    <= '0;
            hit    <= 1'b0;
            invuln <= 1'b0;
        end else begin
            lives  <= lives_next;
            cnt    <= cnt_next;
            hit    <= accept;
            invuln <= (cnt_next != '0);
        end
    end
endmodule

// File: rtl/game_judge.sv
// rtl/game_judge.sv - round FSM, outcome and win tallies over two player_health instances
module game_judge
    import bomb_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int INVULN_CYCLES = 45
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [GRID_N-1:0] explode,
    input  logic [7:0]        p1_cor,
    input  logic [7:0]        p2_cor,
    input  logic              restart,
    output logic [1:0]        game_status,
    output logic [1:0]        p1_lives,
    output logic [1:0]        p2_lives,
    output logic              p1_hit,
    output logic              p2_hit,
    output logic              p1_invuln,
    output logic              p2_invuln,
    output logic [3:0]        p1_score,
    output logic [3:0]        p2_score,
    output logic              freeze
);
    typedef enum logic {PLAY, OVER} state_e;

    state_e       state;
    game_status_e status;
    logic [1:0]   p1_ln;
    logic [1:0]   p2_ln;
    logic         enable;

    assign enable      = (state == PLAY);
    assign game_status = status;

    player_health #(.LIVES(LIVES), .INVULN_CYCLES(INVULN_CYCLES)) u_p1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .reinit(restart),
        .explode(explode), .cor(p1_cor), .lives(p1_lives), .lives_next(p1_ln),
        .hit(p1_hit), .invuln(p1_invuln)
    );

    player_health #(.LIVES(LIVES), .INVULN_CYCLES(INVULN_CYCLES)) u_p2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .reinit(restart),
        .explode(explode), .cor(p2_cor), .lives(p2_lives), .lives_next(p2_ln),
        .hit(p2_hit), .invuln(p2_invuln)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= PLAY;
            status   <= NOT_OVER;
            freeze   <= 1'b0;
            p1_score <= 4'd0;
            p2_score <= 4'd0;
        end else if (restart) begin
            state  <= PLAY;
            status <= NOT_OVER;
            freeze <= 1'b0;
        end else if (state == PLAY) begin
            if (p1_ln == 2'd0 && p2_ln == 2'd0) begin
                state  <= OVER;
                status <= GAME_OVER;
                freeze <= 1'b1;
            end else if (p1_ln == 2'd0) begin
                state    <= OVER;
                status   <= P2_WIN;
                freeze   <= 1'b1;
                p2_score <= sat_inc4(p2_score);
            end else if (p2_ln == 2'd0) begin
                state    <= OVER;
                status   <= P1_WIN;
                freeze   <= 1'b1;
                p1_score <= sat_inc4(p1_score);
            end
        end
    end
endmodule
